// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle CPU phase sequencer and control unit.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  localparam int STATE_W = 3;

  // Sequencer states; HALTED and ERROR share ST_STOP and are told apart by mem_err.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_IF    = 3'd1,
    ST_ID    = 3'd2,
    ST_ALU   = 3'd3,
    ST_MEM   = 3'd4,
    ST_RB    = 3'd5,
    ST_PAUSE = 3'd6,
    ST_STOP  = 3'd7
  } state_t;

  // Stage indices into the strobe vector, shared with the control unit.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_ALU = 2;
  localparam int STG_MEM = 3;
  localparam int STG_RB  = 4;
  localparam int STG_NUM = 5;

  // True while an instruction is in flight.
  function automatic logic is_busy(input state_t s);
    return (s == ST_IF) || (s == ST_ID) || (s == ST_ALU) ||
           (s == ST_MEM) || (s == ST_RB);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose: counts MEM wait cycles and flags the cycle whose increment reaches MEM_TIMEOUT.
// Latency: o_timeout is combinational from the current count and i_inc.
// Backpressure: none; the owner decides when to clear and increment.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;
  // Timeout fires in the wait cycle whose increment would land on MEM_TIMEOUT.
  assign o_timeout = i_inc && (w_cnt_inc == CNT_W'(MEM_TIMEOUT));

  // Wait counter: cleared on MEM entry, stepped on each unready wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Purpose: phase sequencer producing one-cycle IF/ID/ALU/MEM/RB strobes with halt, step and timeout stop.
// Latency: strobes are registered and coincide with the first cycle of their state; 7-cycle minimum instruction.
// Backpressure: MEM is stretched while a request is pending and mem_ready is low, up to MEM_TIMEOUT cycles.
module stage_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 16,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step_mode,
  input  logic               halt,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               mem_ready,
  output logic               IF_clk,
  output logic               ID_clk,
  output logic               ALU_clk,
  output logic               MEM_clk,
  output logic               RB_BR_clk,
  output logic               busy,
  output logic               halted,
  output logic               mem_err,
  output logic [STATE_W-1:0] state_o,
  output logic [COUNT_W-1:0] instr_cnt
);

  state_t               r_state;
  state_t               w_next;
  logic                 r_sub;      // 1 once the current state has lasted past its first cycle
  logic                 r_auto;     // one-shot auto start after reset release
  logic                 r_mem_err;
  logic [COUNT_W-1:0]   r_cnt;
  logic [STG_NUM-1:0]   r_stb;
  logic [STG_NUM-1:0]   w_stb_nxt;
  logic                 w_enter;
  logic                 w_mem_req;
  logic                 w_timer_clr;
  logic                 w_timer_inc;
  logic                 w_timeout;
  logic                 w_retire;

  assign w_mem_req   = mem_read | mem_write;
  assign w_timer_clr = (r_state == ST_MEM) && !r_sub;
  assign w_timer_inc = (r_state == ST_MEM) && r_sub && w_mem_req && !mem_ready;
  assign w_retire    = (r_state == ST_RB) && r_sub && !halt;
  assign w_enter     = (w_next != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_timer_clr),
    .i_inc    (w_timer_inc),
    .o_timeout(w_timeout)
  );

  // Next-state decode; holding is the default, ready beats timeout in MEM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start || r_auto) w_next = ST_IF;
      ST_IF:    w_next = ST_ID;
      ST_ID:    w_next = ST_ALU;
      ST_ALU:   w_next = ST_MEM;
      ST_MEM: begin
        if (r_sub) begin
          if (!w_mem_req || mem_ready) w_next = ST_RB;
          else if (w_timeout)          w_next = ST_STOP;
        end
      end
      ST_RB: begin
        if (r_sub) begin
          if (halt)           w_next = ST_STOP;
          else if (step_mode) w_next = ST_PAUSE;
          else                w_next = ST_IF;
        end
      end
      ST_PAUSE: if (start) w_next = ST_IF;
      ST_STOP:  if (start) w_next = ST_IF;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Strobe for a stage fires only on the cycle that state is entered.
  always_comb begin
    w_stb_nxt          = '0;
    w_stb_nxt[STG_IF]  = w_enter && (w_next == ST_IF);
    w_stb_nxt[STG_ID]  = w_enter && (w_next == ST_ID);
    w_stb_nxt[STG_ALU] = w_enter && (w_next == ST_ALU);
    w_stb_nxt[STG_MEM] = w_enter && (w_next == ST_MEM);
    w_stb_nxt[STG_RB]  = w_enter && (w_next == ST_RB);
  end

  // State register with first-cycle tracking and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sub   <= 1'b0;
      r_stb   <= '0;
    end else begin
      r_state <= w_next;
      r_sub   <= !w_enter;
      r_stb   <= w_stb_nxt;
    end
  end

  // Auto start is armed by reset and consumed on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto <= AUTO_START;
    end else begin
      r_auto <= 1'b0;
    end
  end

  // Memory error flag: set on timeout stop, cleared when restarted from the stop state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_err <= 1'b0;
    end else if ((r_state == ST_MEM) && (w_next == ST_STOP)) begin
      r_mem_err <= 1'b1;
    end else if ((r_state == ST_STOP) && (w_next == ST_IF)) begin
      r_mem_err <= 1'b0;
    end
  end

  // Retired-instruction counter; halting instructions are not counted, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_retire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign IF_clk    = r_stb[STG_IF];
  assign ID_clk    = r_stb[STG_ID];
  assign ALU_clk   = r_stb[STG_ALU];
  assign MEM_clk   = r_stb[STG_MEM];
  assign RB_BR_clk = r_stb[STG_RB];
  assign busy      = is_busy(r_state);
  assign halted    = (r_state == ST_STOP) && !r_mem_err;
  assign mem_err   = r_mem_err;
  assign state_o   = r_state;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_stage_sequencer.sv
// Purpose: directed self-checking bench for stage_sequencer with a strobe scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_stage_sequencer;

  localparam int MEM_TIMEOUT = 16;
  localparam int COUNT_W     = 4;

  localparam logic [4:0] S_IF  = 5'b00001;
  localparam logic [4:0] S_ID  = 5'b00010;
  localparam logic [4:0] S_ALU = 5'b00100;
  localparam logic [4:0] S_MEM = 5'b01000;
  localparam logic [4:0] S_RB  = 5'b10000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               step_mode;
  logic               halt;
  logic               mem_read;
  logic               mem_write;
  logic               mem_ready;
  logic               IF_clk;
  logic               ID_clk;
  logic               ALU_clk;
  logic               MEM_clk;
  logic               RB_BR_clk;
  logic               busy;
  logic               halted;
  logic               mem_err;
  logic [2:0]         state_o;
  logic [COUNT_W-1:0] instr_cnt;

  stage_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .COUNT_W    (COUNT_W),
    .AUTO_START (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step_mode(step_mode),
    .halt     (halt),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_ready(mem_ready),
    .IF_clk   (IF_clk),
    .ID_clk   (ID_clk),
    .ALU_clk  (ALU_clk),
    .MEM_clk  (MEM_clk),
    .RB_BR_clk(RB_BR_clk),
    .busy     (busy),
    .halted   (halted),
    .mem_err  (mem_err),
    .state_o  (state_o),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected strobe: which stage, and cycles since the previous strobe (0 = don't care).
  typedef struct {
    logic [4:0] code;
    int         gap;
  } stb_t;

  stb_t       sb_q[$];
  int         cyc = 0;
  int         last_cyc = 0;
  logic [4:0] mon_v;
  stb_t       mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input int gap_if, input int gap_rb);
    sb_q.push_back('{S_IF, gap_if});
    sb_q.push_back('{S_ID, 1});
    sb_q.push_back('{S_ALU, 1});
    sb_q.push_back('{S_MEM, 1});
    sb_q.push_back('{S_RB, gap_rb});
  endtask

  task automatic push_partial(input int gap_if);
    sb_q.push_back('{S_IF, gap_if});
    sb_q.push_back('{S_ID, 1});
    sb_q.push_back('{S_ALU, 1});
    sb_q.push_back('{S_MEM, 1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Strobe monitor: every strobe must be one-hot and match the next scoreboard entry.
  always @(negedge clk) begin
    mon_v = {RB_BR_clk, MEM_clk, ALU_clk, ID_clk, IF_clk};
    if (mon_v != 5'b0) begin
      chk("strobe_onehot", 32'($onehot(mon_v)), 32'd1);
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 32'(mon_v), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("strobe_code", 32'(mon_v), 32'(mon_e.code));
        if (mon_e.gap != 0) chk("strobe_gap", 32'(cyc - last_cyc), 32'(mon_e.gap));
      end
      last_cyc = cyc;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; halt = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_strobes", 32'({RB_BR_clk, MEM_clk, ALU_clk, ID_clk, IF_clk}), 32'd0);

    // Three plain instructions, one with a stretched MEM, one that times out.
    push_instr(0, 2); push_instr(2, 2); push_instr(2, 2);
    push_instr(2, 6);
    push_partial(2);
    rst_n = 1'b1;
    tick(1);                                   // first IF
    chk("auto_start_state", 32'(state_o), 32'd1);
    chk("auto_start_busy", 32'(busy), 32'd1);
    tick(21);                                  // IF of instruction 4
    chk("cnt_after_3", 32'(instr_cnt), 32'd3);
    chk("state_if4", 32'(state_o), 32'd1);

    tick(3);                                   // MEM cycle 0
    chk("mem0_state", 32'(state_o), 32'd4);
    mem_read = 1'b1;
    tick(1);
    chk("mem1_state", 32'(state_o), 32'd4);
    tick(4);                                   // MEM cycle 5
    chk("mem5_state", 32'(state_o), 32'd4);
    mem_ready = 1'b1;
    tick(1);
    chk("rb_after_ready", 32'(state_o), 32'd5);
    mem_read = 1'b0; mem_ready = 1'b0;
    tick(2);
    chk("cnt_after_4", 32'(instr_cnt), 32'd4);

    tick(3);                                   // MEM cycle 0, write never acknowledged
    chk("wr_mem0_state", 32'(state_o), 32'd4);
    mem_write = 1'b1;
    tick(16);
    chk("wait16_still_mem", 32'(state_o), 32'd4);
    tick(1);
    chk("err_state", 32'(state_o), 32'd7);
    chk("err_flag", 32'(mem_err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_halted", 32'(halted), 32'd0);
    chk("err_cnt", 32'(instr_cnt), 32'd4);
    mem_write = 1'b0;
    tick(10);
    chk("err_hold_state", 32'(state_o), 32'd7);

    // Restart from ERROR, then halt this instruction.
    push_instr(0, 2);
    pulse_start();
    chk("err_restart_state", 32'(state_o), 32'd1);
    chk("err_restart_if", 32'(IF_clk), 32'd1);
    chk("err_restart_flag", 32'(mem_err), 32'd0);
    tick(6);                                   // RB cycle 1
    chk("rb1_state", 32'(state_o), 32'd5);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("halt_state", 32'(state_o), 32'd7);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_mem_err", 32'(mem_err), 32'd0);
    chk("halt_cnt", 32'(instr_cnt), 32'd4);
    tick(50);
    chk("halt_hold", 32'(halted), 32'd1);

    // Single-step: each start gives exactly one instruction.
    step_mode = 1'b1;
    push_instr(0, 2);
    pulse_start();
    chk("halt_resume_flag", 32'(halted), 32'd0);
    chk("halt_resume_state", 32'(state_o), 32'd1);
    tick(7);
    chk("pause_state", 32'(state_o), 32'd6);
    chk("pause_cnt", 32'(instr_cnt), 32'd5);
    chk("pause_busy", 32'(busy), 32'd0);
    tick(5);
    chk("pause_hold", 32'(state_o), 32'd6);
    push_instr(0, 2);
    pulse_start();                             // IF
    tick(1);                                   // ID; start here must be ignored
    pulse_start();
    chk("start_ignored", 32'(state_o), 32'd3);
    tick(5);
    chk("step1_state", 32'(state_o), 32'd6);
    chk("step1_cnt", 32'(instr_cnt), 32'd6);
    push_instr(0, 2);
    pulse_start();
    tick(7);
    chk("step2_state", 32'(state_o), 32'd6);
    chk("step2_cnt", 32'(instr_cnt), 32'd7);

    // Free run through the counter wrap, then reset during a MEM wait.
    step_mode = 1'b0;
    push_instr(0, 2);
    for (int i = 0; i < 23; i++) push_instr(2, 2);
    push_partial(2);
    pulse_start();
    tick(56);
    chk("cnt_15", 32'(instr_cnt), 32'd15);
    tick(7);
    chk("cnt_wrap", 32'(instr_cnt), 32'd0);
    tick(105);
    chk("cnt_15_again", 32'(instr_cnt), 32'd15);
    tick(3);
    chk("final_mem0", 32'(state_o), 32'd4);
    mem_read = 1'b1;
    tick(3);
    chk("final_wait_state", 32'(state_o), 32'd4);
    chk("final_wait_cnt", 32'(instr_cnt), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(instr_cnt), 32'd0);
    chk("arst_flags", 32'({halted, mem_err}), 32'd0);
    chk("arst_strobes", 32'({RB_BR_clk, MEM_clk, ALU_clk, ID_clk, IF_clk}), 32'd0);
    tick(3);
    chk("arst_hold_state", 32'(state_o), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
